avalon_sdram_bridge: RTL



---
 rtl/avalon_sdram_bridge.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/avalon_sdram_bridge.sv
// Avalon-MM burst slave that drives the SDRAM controller host port.
// One Avalon read or write burst becomes exactly one controller transaction.
// Write beats are buffered ahead of IN_REQ; read beats are forwarded under OUT_VALID.
module avalon_sdram_bridge #(
  parameter int ASIZE    = 23,
  parameter int DSIZE    = 16,
  parameter int MAXBURST = 8
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [ASIZE-1:0]     AV_ADDRESS,
  input  logic                 AV_READ,
  input  logic                 AV_WRITE,
  input  logic [7:0]           AV_BURSTCOUNT,
  input  logic [DSIZE-1:0]     AV_WRITEDATA,
  input  logic [DSIZE/8-1:0]   AV_BYTEENABLE,
  output logic                 AV_WAITREQUEST,
  output logic [DSIZE-1:0]     AV_READDATA,
  output logic                 AV_READDATAVALID,
  output logic [ASIZE-1:0]     ADDR,
  output logic                 WR,
  output logic                 RD,
  output logic [7:0]           LENGTH,
  output logic [DSIZE-1:0]     DATAIN,
  output logic [DSIZE/8-1:0]   DM,
  input  logic                 IN_REQ,
  input  logic                 OUT_VALID,
  input  logic [DSIZE-1:0]     DATAOUT,
  input  logic                 DONE
);

  localparam int BW = DSIZE / 8;
  localparam int IW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam int PW = IW + 1;
  localparam logic [7:0] MAXB8 = 8'(MAXBURST);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WFILL   = 3'd1;
  localparam logic [2:0] S_WISSUE  = 3'd2;
  localparam logic [2:0] S_RISSUE  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             done_m;
  logic             done_s;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    rcnt;
  logic [7:0]       wptr_x;
  logic [7:0]       rptr_x;
  logic [7:0]       rcnt_x;
  logic [7:0]       last_idx;
  logic [7:0]       cnt_in;
  logic             wr_accept_idle;

  logic [DSIZE-1:0] wbuf_data [MAXBURST];
  logic [BW-1:0]    wbuf_mask [MAXBURST];

  assign wptr_x         = 8'(wptr);
  assign rptr_x         = 8'(rptr);
  assign rcnt_x         = 8'(rcnt);
  assign last_idx       = LENGTH - 8'd1;
  assign wr_accept_idle = (state == S_IDLE) && AV_WRITE && !AV_READ;

  assign WR     = (state == S_WISSUE);
  assign RD     = (state == S_RISSUE);
  assign DATAIN = (state == S_WISSUE) ? wbuf_data[rptr[IW-1:0]] : '0;
  assign DM     = (state == S_WISSUE) ? wbuf_mask[rptr[IW-1:0]] : '1;

  // DONE comes from outside this clock's timing; two-flop synchronizer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= DONE;
      done_s <= done_m;
    end
  end

  // Normalise burst count: 0 means a single beat; anything above the buffer depth is clamped
  always_comb begin
    cnt_in = AV_BURSTCOUNT;
    if (AV_BURSTCOUNT == 8'd0)
      cnt_in = 8'd1;
    else if (AV_BURSTCOUNT > MAXB8)
      cnt_in = MAXB8;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (AV_READ)
          state_nxt = S_RISSUE;
        else if (AV_WRITE)
          state_nxt = (cnt_in == 8'd1) ? S_WISSUE : S_WFILL;
      end
      S_WFILL:   if (AV_WRITE && (wptr_x == last_idx)) state_nxt = S_WISSUE;
      S_WISSUE:  if (done_s && (rptr_x == last_idx))   state_nxt = S_RELEASE;
      S_RISSUE:  if (done_s && (rcnt_x == LENGTH))     state_nxt = S_RELEASE;
      // Entry into RELEASE needs done_s high, so at least one cycle is spent here
      // and the controller always sees WR/RD low before the next request edge.
      S_RELEASE: if (!done_s)                          state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Main control: state, command latches, pointers and read-return path
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= S_IDLE;
      AV_WAITREQUEST   <= 1'b1;
      AV_READDATA      <= '0;
      AV_READDATAVALID <= 1'b0;
      ADDR             <= '0;
      LENGTH           <= '0;
      wptr             <= '0;
      rptr             <= '0;
      rcnt             <= '0;
    end else begin
      state            <= state_nxt;
      AV_WAITREQUEST   <= !((state_nxt == S_IDLE) || (state_nxt == S_WFILL));
      AV_READDATAVALID <= 1'b0;
      case (state)
        S_IDLE: begin
          rptr <= '0;
          rcnt <= '0;
          wptr <= '0;
          if (AV_READ) begin
            ADDR   <= AV_ADDRESS;
            LENGTH <= cnt_in;
          end else if (AV_WRITE) begin
            ADDR   <= AV_ADDRESS;
            LENGTH <= cnt_in;
            wptr   <= PW'(1);
          end
        end
        S_WFILL: begin
          if (AV_WRITE)
            wptr <= wptr + PW'(1);
        end
        S_WISSUE: begin
          if (IN_REQ && (rptr_x != last_idx))
            rptr <= rptr + PW'(1);
        end
        S_RISSUE: begin
          if (OUT_VALID && (rcnt_x < LENGTH)) begin
            AV_READDATA      <= DATAOUT;
            AV_READDATAVALID <= 1'b1;
            rcnt             <= rcnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Write beat buffer; contents are only visible in WISSUE so no reset is needed
  always_ff @(posedge CLK) begin
    if (wr_accept_idle) begin
      wbuf_data[0] <= AV_WRITEDATA;
      wbuf_mask[0] <= ~AV_BYTEENABLE;
    end else if ((state == S_WFILL) && AV_WRITE) begin
      wbuf_data[wptr[IW-1:0]] <= AV_WRITEDATA;
      wbuf_mask[wptr[IW-1:0]] <= ~AV_BYTEENABLE;
    end
  end

endmodule
